fetch_decode_stage: RTL and testbench
=====================================

# fetch_decode_stage

Fetch stage and IF/ID pipeline register of the pipelined ARM core. It holds the program counter, selects the next PC from PC+4, the early branch target, or a write-back PC write, and presents the fetched instruction to Decode. It directly consumes the StallF, StallD and FlushD outputs of the hazard unit, plus the PC-redirect signals from Execute and Writeback. Two saturating counters record stall cycles and squashed fetches for performance analysis.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 16, width of each performance counter
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- StallF  in  1  hold PCF (from hazard unit)
- StallD  in  1  hold IF/ID register (from hazard unit)
- FlushD  in  1  squash IF/ID register (from hazard unit)
- BranchTakenE  in  1  conditional branch resolved taken in Execute
- ALUResultE  in  32  branch target computed in Execute
- PCSrcW  in  1  instruction in Writeback writes the PC
- ResultW  in  32  value written to PC by Writeback
- InstrF  in  32  instruction-memory read data for address PCF, combinational
- CountClr  in  1  synchronous clear of both counters
- PCF  out  32  current fetch address, drives instruction memory
- InstrD  out  32  instruction in Decode
- PCD  out  32  address of InstrD
- PCPlus8D  out  32  PCD + 8, ARM R15 read value for Decode
- ValidD  out  1  InstrD is a real instruction (0 after reset or flush)
- StallCount  out  CNT_WIDTH  cycles with StallD=1
- FlushCount  out  CNT_WIDTH  cycles in which a fetch was squashed

## Operation
- Next-PC priority: BranchTakenE -> ALUResultE; else PCSrcW -> ResultW; else PCF+4.
- PC register: loads next-PC when StallF=0 or when a redirect (BranchTakenE or PCSrcW) is asserted; a redirect overrides StallF so a target is never lost. Otherwise it holds.
- IF/ID register, evaluated in order:
  - rst_n=0: InstrD=0, PCD=0, ValidD=0.
  - StallD=1: hold all fields. StallD overrides FlushD.
  - FlushD=1: InstrD=32'h0, PCD=0, ValidD=0.
  - Otherwise: InstrD<=InstrF, PCD<=PCF, ValidD<=1.
- PCPlus8D = PCD+8, combinational from the register.
- Address arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are passed through unmodified, with no alignment check.
- StallCount increments on every cycle with StallD=1.
- FlushCount increments on every cycle with FlushD=1 and StallD=0.
- Both counters saturate at all-ones. CountClr=1 zeroes them and overrides the increment for that cycle.

## Timing
- Reset values: PCF=RESET_PC, InstrD=0, PCD=0, PCPlus8D=8, ValidD=0, StallCount=0, FlushCount=0.
- Reset is sampled only on the clock edge. Asserting it mid-operation discards the pending redirect and any in-flight IF/ID contents on that edge.
- First cycle after reset release: PCF=RESET_PC. On the next edge, InstrD=mem[RESET_PC], ValidD=1, PCF=RESET_PC+4.
- Fetch-to-Decode latency is 1 cycle.
- Redirect: BranchTakenE or PCSrcW high in cycle n gives PCF=target in cycle n+1. The hazard unit flushes the wrong-path fetch via FlushD in cycle n.
- BranchTakenE and PCSrcW high together: ALUResultE wins.
- Counter outputs reflect events up to the previous edge.
- No combinational path from any input to PCF, InstrD, PCD or ValidD. PCPlus8D depends only on PCD.

## Test plan
- Reset/sequential fetch: RESET_PC=0x100, hold rst_n=0 for 2 cycles, then run 4 cycles with no stalls -> PCF=0x100,0x104,0x108,0x10C,0x110; InstrD follows one cycle behind; PCPlus8D=PCD+8; ValidD rises one cycle after release.
- Load-use stall: StallF=StallD=1 for 1 cycle at PCF=0x108 -> PCF and InstrD hold for one cycle; StallCount=1; FlushCount=0.
- Branch redirect: BranchTakenE=1, ALUResultE=0x200, FlushD=1 -> next PCF=0x200, ValidD=0, InstrD=0, FlushCount+1.
- Priority and override: StallF=1 with PCSrcW=1, ResultW=0x300 -> PCF=0x300. Then BranchTakenE=1 (ALUResultE=0x400) and PCSrcW=1 (ResultW=0x500) together -> PCF=0x400. StallD=1 with FlushD=1 -> IF/ID holds and FlushCount is unchanged.
- Wrap and counters: PCF=0xFFFF_FFFC -> next PCF=0x0. With CNT_WIDTH=4, 20 stall cycles -> StallCount saturates at 15. CountClr=1 together with StallD=1 -> StallCount=0.
- Mid-run reset: assert rst_n=0 in the same cycle as BranchTakenE=1 -> PCF=RESET_PC, ValidD=0, counters=0.

Source files
------------

// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_stage
// Brief    : Program counter, next-PC select and IF/ID pipeline register of
//            the pipelined ARM core, with saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 BranchTakenE,
  input  logic [31:0]          ALUResultE,
  input  logic                 PCSrcW,
  input  logic [31:0]          ResultW,
  input  logic [31:0]          InstrF,
  input  logic                 CountClr,
  output logic [31:0]          PCF,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus8D,
  output logic                 ValidD,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0]          pc_q;
  logic [31:0]          pc_d;
  logic                 w_redirect;
  logic [31:0]          instr_q;
  logic [31:0]          pcd_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_d;

  // Next-PC select: an Execute branch beats a Writeback PC write, else PC+4.
  always_comb begin
    w_redirect = BranchTakenE | PCSrcW;
    if (BranchTakenE) begin
      pc_d = ALUResultE;
    end else if (PCSrcW) begin
      pc_d = ResultW;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register; a redirect loads even while stalled so the target survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (!StallF || w_redirect) begin
      pc_q <= pc_d;
    end
  end

  // IF/ID register: stall holds (and masks flush), flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
      pcd_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (StallD) begin
      instr_q <= instr_q;
      pcd_q   <= pcd_q;
      valid_q <= valid_q;
    end else if (FlushD) begin
      instr_q <= 32'h0;
      pcd_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= InstrF;
      pcd_q   <= pc_q;
      valid_q <= 1'b1;
    end
  end

  // Counter next-state: clear wins, otherwise saturating increment on event.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CountClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallD && (stall_cnt_q != C_CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + C_CNT_ONE;
      end
      if (FlushD && !StallD && (flush_cnt_q != C_CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + C_CNT_ONE;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PCD        = pcd_q;
  assign PCPlus8D   = pcd_q + 32'd8;
  assign ValidD     = valid_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_stage
// Brief    : Self-checking bench for fetch_decode_stage: directed vector table
//            followed by randomized cycles against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, StallF, StallD, FlushD, BranchTakenE, PCSrcW, CountClr;
  logic [31:0]   ALUResultE, ResultW, InstrF;
  logic [31:0]   PCF, InstrD, PCD, PCPlus8D;
  logic          ValidD;
  logic [CW-1:0] StallCount, FlushCount;

  int n_cmp = 0;
  int n_err = 0;

  fetch_decode_stage #(.RESET_PC(RST_PC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
    .ResultW(ResultW), .InstrF(InstrF), .CountClr(CountClr), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: an address-dependent pattern, never zero.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE000_0001;
  endfunction

  always_comb InstrF = imem(PCF);

  typedef struct {
    logic        rst_n, sf, sd, fd, bt;
    logic [31:0] alu;
    logic        pcs;
    logic [31:0] resw;
    logic        clr;
    logic [31:0] e_pcf, e_pcd;
    logic        e_valid;
    int          e_sc, e_fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, sf, sd, fd, bt, input logic [31:0] alu,
                              input logic pcs, input logic [31:0] resw, input logic clr,
                              input logic [31:0] pcf, pcd, input logic v, input int sc, fc);
    vec_t t;
    t.rst_n = r; t.sf = sf; t.sd = sd; t.fd = fd; t.bt = bt; t.alu = alu;
    t.pcs = pcs; t.resw = resw; t.clr = clr; t.e_pcf = pcf; t.e_pcd = pcd;
    t.e_valid = v; t.e_sc = sc; t.e_fc = fc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; StallF = v.sf; StallD = v.sd; FlushD = v.fd;
    BranchTakenE = v.bt; ALUResultE = v.alu; PCSrcW = v.pcs; ResultW = v.resw;
    CountClr = v.clr;
  endtask

  // Drive one cycle, clock it, then compare every output against expectations.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] e_instr;
    drive(v);
    @(posedge clk);
    #1;
    e_instr = v.e_valid ? imem(v.e_pcd) : 32'h0;
    check({tag, ".PCF"},        PCF,                 v.e_pcf);
    check({tag, ".PCD"},        PCD,                 v.e_pcd);
    check({tag, ".InstrD"},     InstrD,              e_instr);
    check({tag, ".PCPlus8D"},   PCPlus8D,            v.e_pcd + 32'd8);
    check({tag, ".ValidD"},     {31'b0, ValidD},     {31'b0, v.e_valid});
    check({tag, ".StallCount"}, {28'b0, StallCount}, v.e_sc);
    check({tag, ".FlushCount"}, {28'b0, FlushCount}, v.e_fc);
  endtask

  // Behavioural model state for the random phase.
  logic [31:0] m_pc, m_pcd, m_instr;
  logic        m_valid;
  int          m_sc, m_fc;

  initial begin
    vec_t v;
    int   sc;
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0;
    PCSrcW = 1'b0; CountClr = 1'b0; ALUResultE = 32'h0; ResultW = 32'h0;

    //                r  sF sD fD bt alu            pcs resw          clr pcf            pcd            v  sc fc
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h100,       32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h100,       32'h0,         0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h104,       32'h100,       1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h108,       32'h104,       1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         0,  32'h0,        0,  32'h108,       32'h104,       1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h10C,       32'h108,       1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h110,       32'h10C,       1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h200,       0,  32'h0,        0,  32'h200,       32'h0,         0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h204,       32'h200,       1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1,  32'h300,      0,  32'h300,       32'h204,       1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h400,       1,  32'h500,      0,  32'h400,       32'h0,         0, 1, 2));
    vecs.push_back(mk(1, 1, 1, 1, 0, 32'h0,         0,  32'h0,        0,  32'h400,       32'h0,         0, 2, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h404,       32'h400,       1, 2, 2));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0,  32'h0,        0,  32'hFFFF_FFFC, 32'h0,         0, 2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h0,         32'hFFFF_FFFC, 1, 2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         0,  32'h0,        0,  32'h4,         32'h0,         1, 2, 3));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Long stall: StallCount saturates at all-ones, pipeline holds.
    sc = 2;
    for (int i = 0; i < 20; i++) begin
      sc = (sc < CMAX) ? sc + 1 : CMAX;
      apply(mk(1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 32'h0, 1, sc, 3), $sformatf("sat%0d", i));
    end
    // Clear together with a stall: clear wins.
    apply(mk(1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 1, 32'h4, 32'h0, 1, 0, 0), "clr");
    // Unaligned target passes through untouched.
    apply(mk(1, 0, 0, 1, 1, 32'h203, 0, 32'h0, 0, 32'h203, 32'h0, 0, 0, 1), "odd0");
    apply(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h207, 32'h203, 1, 0, 1), "odd1");
    // Reset on the same edge as a taken branch discards the redirect.
    apply(mk(0, 0, 0, 1, 1, 32'h999, 0, 32'h0, 0, 32'h100, 32'h0, 0, 0, 0), "midrst");
    apply(mk(1, 0, 0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h104, 32'h100, 1, 0, 0), "postrst");

    // Randomized phase against the behavioural model.
    for (int i = 0; i < 400; i++) begin
      v.rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      v.sd    = ($urandom_range(0, 3) == 0);
      v.sf    = v.sd | ($urandom_range(0, 7) == 0);
      v.fd    = ($urandom_range(0, 5) == 0);
      v.bt    = ($urandom_range(0, 7) == 0);
      v.pcs   = ($urandom_range(0, 9) == 0);
      v.alu   = $urandom;
      v.resw  = $urandom;
      v.clr   = ($urandom_range(0, 29) == 0);

      if (!v.rst_n) begin
        m_pc = RST_PC; m_pcd = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_sc = 0; m_fc = 0;
      end else begin
        // IF/ID capture uses the fetch address of this cycle.
        if (!v.sd) begin
          if (v.fd) begin
            m_instr = 32'h0; m_pcd = 32'h0; m_valid = 1'b0;
          end else begin
            m_instr = imem(m_pc); m_pcd = m_pc; m_valid = 1'b1;
          end
        end
        if (v.bt)        m_pc = v.alu;
        else if (v.pcs)  m_pc = v.resw;
        else if (!v.sf)  m_pc = m_pc + 32'd4;
        if (v.clr) begin
          m_sc = 0; m_fc = 0;
        end else begin
          if (v.sd) m_sc = (m_sc + 1 > CMAX) ? CMAX : m_sc + 1;
          if (v.fd && !v.sd) m_fc = (m_fc + 1 > CMAX) ? CMAX : m_fc + 1;
        end
      end

      drive(v);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d.PCF", i),        PCF,                 m_pc);
      check($sformatf("rnd%0d.PCD", i),        PCD,                 m_pcd);
      check($sformatf("rnd%0d.InstrD", i),     InstrD,              m_instr);
      check($sformatf("rnd%0d.PCPlus8D", i),   PCPlus8D,            m_pcd + 32'd8);
      check($sformatf("rnd%0d.ValidD", i),     {31'b0, ValidD},     {31'b0, m_valid});
      check($sformatf("rnd%0d.StallCount", i), {28'b0, StallCount}, m_sc);
      check($sformatf("rnd%0d.FlushCount", i), {28'b0, FlushCount}, m_fc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
